control_unit: RTL and testbench
===============================

# control_unit

Hardwired control sequencer for the accumulator CPU. It steps each instruction through fetch, decode and execute. It drives the one-hot-per-operation control word `ctrl` that loads the PC/MAR/MBR/IR/BR registers and selects the ALU/accumulator operation (`ctrl[8]`, `ctrl[9]`, `ctrl[13]`, `ctrl[15]`–`ctrl[21]`). It stalls on a memory ready handshake, evaluates the ALU sign flag for conditional jumps, and halts on HALT.

## Interface
- No parameters; opcode field is 8 bits, `ctrl` is 22 bits.
- `clk` in 1: single system clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: level; leaves IDLE on the first cycle seen high.
- `ir_op` in 8: IR[15:8], valid from the cycle after IR is loaded.
- `ALUflags` in 4: {Z, N, C, V} from the accumulator; only bit 2 (N) is used.
- `mem_ready` in 1: memory completes the current read/write this cycle.
- `mem_rd` out 1: memory read request.
- `mem_wr` out 1: memory write request.
- `ctrl` out 22: bit *i* = control signal C*i*; a bit not listed under Operation is 0.
- `busy` out 1: high in every state except IDLE and HALT.
- `halted` out 1: high in HALT.

## Operation
- Control bits used:
  - C3 MBR<=M[MAR]; C4 IR<=MBR[15:8]; C5 MAR<=MBR[7:0]; C6 PC<=PC+1
  - C7 BR<=MBR; C8 ACC<=0; C9 add; C10 MAR<=PC; C11 M[MAR]<=MBR
  - C12 MBR<=ACC; C13 sub; C14 PC<=MBR[7:0]; C15 mul; C16 div
  - C17 shr; C18 shl; C19 and; C20 or; C21 not
  - C0–C2 are always 0.
- Opcodes:
  - Memory operand: 01 STORE, 02 LOAD, 03 ADD, 04 SUB, 08 MPY, 09 DIV, 0A AND, 0B OR
  - Jumps: 05 JMPGEZ, 06 JMP
  - No operand: 07 HALT, 0C NOT, 0D SHR, 0E SHL
  - Any other opcode is a NOP.
- States and outputs:
  - IDLE: `ctrl`=0. Goes to F0 if `start`=1.
  - F0: C10. Goes to F1.
  - F1: `mem_rd`=1; C3 and C6 only in the cycle `mem_ready`=1. Stays in F1 until `mem_ready`=1, then goes to F2.
  - F2: C4, C5. Goes to DEC.
  - DEC: `ctrl`=0; branches on `ir_op`:
    - memory-operand ops → RD
    - STORE → ST
    - JMP/JMPGEZ → JMP
    - NOT/SHR/SHL → ALU
    - HALT → HALT
    - NOP → F0
  - RD: `mem_rd`=1; C3 only when `mem_ready`=1. Waits in RD, then goes to BR.
  - BR: C7; C8 also if the op is LOAD. Goes to ALU.
  - ALU: exactly one of C9 (LOAD, ADD), C13, C15, C16, C19, C20, C21, C17, C18, per opcode. Goes to F0.
  - ST: C12. Goes to WR.
  - WR: `mem_wr`=1; C11 only when `mem_ready`=1. Waits in WR, then goes to F0.
  - JMP: C14 if JMP, or if JMPGEZ and `ALUflags[2]`=0; otherwise `ctrl`=0. Goes to F0.
  - HALT: `ctrl`=0. Stays in HALT until reset; `start` is ignored.
- `ctrl`, `mem_rd`, `mem_wr` are combinational decodes of the registered state, latched opcode, `mem_ready` and `ALUflags`.
- `ir_op` is captured into an internal register in DEC. Execute states use the latched copy, so an `ir_op` change after DEC has no effect.

## Timing
- Reset (async, any state, including mid-wait): state=IDLE. `ctrl`=0, `mem_rd`=0, `mem_wr`=0, `busy`=0, `halted`=0, latched opcode=0.
  - An outstanding memory request is dropped the same instant.
  - First fetch begins the cycle after `start` is seen high in IDLE.
- Cycles per instruction with `mem_ready` tied 1, counted from entering F0 to re-entering F0:
  - LOAD/ADD/SUB/MPY/DIV/AND/OR: 7
  - STORE: 6
  - JMP/JMPGEZ: 5
  - NOT/SHR/SHL: 5
  - NOP: 4
- Each cycle with `mem_ready`=0 in F1/RD/WR adds one cycle. `mem_rd`/`mem_wr` stay high and C3/C11/C6 stay 0 until the completion cycle.
- `mem_ready` high outside F1/RD/WR is ignored.
- At most one ALU bit among C8/C9/C13/C15–C21 is high in any cycle, except in BR, where C8 alone is allowed.
- JMPGEZ samples N in the JMP cycle itself. This is the flag after the previous instruction's ALU write, which has completed at least 4 cycles earlier.

## Test plan
- Reset then `start`=1, `mem_ready`=1, `ir_op`=03:
  - states F0,F1,F2,DEC,RD,BR,ALU in 7 cycles.
  - `ctrl` asserts C10; C3|C6; C4|C5; 0; C3; C7; C9.
  - `busy` is high from the first cycle after `start`.
- `ir_op`=01 with `mem_ready` low for 3 cycles in WR:
  - `mem_wr` is high for 4 cycles.
  - C11 is asserted only in the 4th.
  - Total is 9 cycles.
- `ir_op`=05 with `ALUflags`=4'b0100: C14 is never asserted.
- `ir_op`=05 with `ALUflags`=4'b0000: C14 is high in the JMP cycle.
- `ir_op`=07:
  - enters HALT, `halted`=1, `busy`=0, `ctrl`=0.
  - pulsing `start` has no effect.
  - `rst_n` low returns to IDLE.
- `ir_op`=FF: NOP, back in F0 after 4 cycles with no ALU bit set.
- `ir_op`=0E: the ALU cycle asserts C18 only.
- Assert `rst_n`=0 in the middle of an RD wait: `mem_rd` and `ctrl` drop to 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/control_unit.sv
// control_unit: hardwired fetch/decode/execute sequencer for the accumulator CPU.
// Drives the 22-bit control word, memory read/write requests and the
// busy/halted status. The opcode is latched in DEC; execute states decode the
// latched copy only.
module control_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  ir_op,
  input  logic [3:0]  ALUflags,
  input  logic        mem_ready,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic [21:0] ctrl,
  output logic        busy,
  output logic        halted
);

  typedef enum logic [3:0] {
    S_IDLE, S_F0, S_F1, S_F2, S_DEC, S_RD, S_BR, S_ALU,
    S_ST, S_WR, S_JMP, S_HALT
  } state_t;

  localparam logic [7:0] OP_STORE  = 8'h01;
  localparam logic [7:0] OP_LOAD   = 8'h02;
  localparam logic [7:0] OP_ADD    = 8'h03;
  localparam logic [7:0] OP_SUB    = 8'h04;
  localparam logic [7:0] OP_JMPGEZ = 8'h05;
  localparam logic [7:0] OP_JMP    = 8'h06;
  localparam logic [7:0] OP_HALT   = 8'h07;
  localparam logic [7:0] OP_MPY    = 8'h08;
  localparam logic [7:0] OP_DIV    = 8'h09;
  localparam logic [7:0] OP_AND    = 8'h0A;
  localparam logic [7:0] OP_OR     = 8'h0B;
  localparam logic [7:0] OP_NOT    = 8'h0C;
  localparam logic [7:0] OP_SHR    = 8'h0D;
  localparam logic [7:0] OP_SHL    = 8'h0E;

  state_t     state_q, state_d;
  logic [7:0] op_q, op_d;
  logic       busy_q, busy_d;
  logic       halted_q, halted_d;

  // Only N participates in control; the other flags are deliberately ignored.
  logic unused_flags;
  assign unused_flags = ^{ALUflags[3], ALUflags[1:0]};

  assign busy   = busy_q;
  assign halted = halted_q;

  // Next-state, opcode latch and registered status decode.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    case (state_q)
      S_IDLE: if (start) state_d = S_F0;
      S_F0:   state_d = S_F1;
      S_F1:   if (mem_ready) state_d = S_F2;
      S_F2:   state_d = S_DEC;
      S_DEC: begin
        op_d = ir_op;
        case (ir_op)
          OP_LOAD, OP_ADD, OP_SUB, OP_MPY,
          OP_DIV, OP_AND, OP_OR:          state_d = S_RD;
          OP_STORE:                       state_d = S_ST;
          OP_JMP, OP_JMPGEZ:              state_d = S_JMP;
          OP_NOT, OP_SHR, OP_SHL:         state_d = S_ALU;
          OP_HALT:                        state_d = S_HALT;
          default:                        state_d = S_F0;
        endcase
      end
      S_RD:   if (mem_ready) state_d = S_BR;
      S_BR:   state_d = S_ALU;
      S_ALU:  state_d = S_F0;
      S_ST:   state_d = S_WR;
      S_WR:   if (mem_ready) state_d = S_F0;
      S_JMP:  state_d = S_F0;
      S_HALT: state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
    busy_d   = !(state_d == S_IDLE || state_d == S_HALT);
    halted_d = (state_d == S_HALT);
  end

  // Sequencer state, latched opcode and status flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      op_q     <= 8'h00;
      busy_q   <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      busy_q   <= busy_d;
      halted_q <= halted_d;
    end
  end

  // Control word and memory strobes decoded from state, latched op and inputs.
  always_comb begin
    ctrl   = 22'd0;
    mem_rd = 1'b0;
    mem_wr = 1'b0;
    case (state_q)
      S_F0: ctrl[10] = 1'b1;
      S_F1: begin
        mem_rd = 1'b1;
        if (mem_ready) begin
          ctrl[3] = 1'b1;
          ctrl[6] = 1'b1;
        end
      end
      S_F2: begin
        ctrl[4] = 1'b1;
        ctrl[5] = 1'b1;
      end
      S_RD: begin
        mem_rd = 1'b1;
        if (mem_ready) ctrl[3] = 1'b1;
      end
      S_BR: begin
        ctrl[7] = 1'b1;
        if (op_q == OP_LOAD) ctrl[8] = 1'b1;
      end
      S_ALU: begin
        case (op_q)
          OP_LOAD, OP_ADD: ctrl[9]  = 1'b1;
          OP_SUB:          ctrl[13] = 1'b1;
          OP_MPY:          ctrl[15] = 1'b1;
          OP_DIV:          ctrl[16] = 1'b1;
          OP_AND:          ctrl[19] = 1'b1;
          OP_OR:           ctrl[20] = 1'b1;
          OP_NOT:          ctrl[21] = 1'b1;
          OP_SHR:          ctrl[17] = 1'b1;
          OP_SHL:          ctrl[18] = 1'b1;
          default:         ctrl     = 22'd0;
        endcase
      end
      S_ST: ctrl[12] = 1'b1;
      S_WR: begin
        mem_wr = 1'b1;
        if (mem_ready) ctrl[11] = 1'b1;
      end
      S_JMP: begin
        // N sampled in this very cycle: clear N means accumulator >= 0.
        if (op_q == OP_JMP || (op_q == OP_JMPGEZ && !ALUflags[2]))
          ctrl[14] = 1'b1;
      end
      default: ctrl = 22'd0;
    endcase
  end

endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: directed per-cycle checks of the control sequencer.
module tb_control_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [7:0]  ir_op;
  logic [3:0]  ALUflags;
  logic        mem_ready;
  logic        mem_rd, mem_wr, busy, halted;
  logic [21:0] ctrl;

  int checks   = 0;
  int failures = 0;

  control_unit dut (
    .clk(clk), .rst_n(rst_n), .start(start), .ir_op(ir_op),
    .ALUflags(ALUflags), .mem_ready(mem_ready), .mem_rd(mem_rd),
    .mem_wr(mem_wr), .ctrl(ctrl), .busy(busy), .halted(halted)
  );

  always #5 clk = ~clk;

  function automatic logic [21:0] c(input int i);
    logic [21:0] v;
    v = 22'd0;
    v[i] = 1'b1;
    return v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  // Drive one cycle's inputs at the falling edge, then check all outputs.
  task automatic cyc(input logic st, input logic rdy, input logic [7:0] op,
                     input logic [3:0] fl, input logic [21:0] ec, input logic erd,
                     input logic ewr, input logic ebusy, input logic ehalt,
                     input string tag);
    @(negedge clk);
    start = st; mem_ready = rdy; ir_op = op; ALUflags = fl;
    #1;
    chk({tag, ".ctrl"},   32'(ctrl),   32'(ec));
    chk({tag, ".rd"},     32'(mem_rd), 32'(erd));
    chk({tag, ".wr"},     32'(mem_wr), 32'(ewr));
    chk({tag, ".busy"},   32'(busy),   32'(ebusy));
    chk({tag, ".halted"}, 32'(halted), 32'(ehalt));
  endtask

  // F0, F1, F2, DEC with memory always ready.
  task automatic fetch(input logic [7:0] op);
    cyc(0, 1, op, 4'h0, c(10),        0, 0, 1, 0, "F0");
    cyc(0, 1, op, 4'h0, c(3) | c(6),  1, 0, 1, 0, "F1");
    cyc(0, 1, op, 4'h0, c(4) | c(5),  0, 0, 1, 0, "F2");
    cyc(0, 1, op, 4'h0, 22'd0,        0, 0, 1, 0, "DEC");
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; ir_op = 8'h00; ALUflags = 4'h0; mem_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst.ctrl",   32'(ctrl),   32'd0);
    chk("rst.rd",     32'(mem_rd), 32'd0);
    chk("rst.wr",     32'(mem_wr), 32'd0);
    chk("rst.busy",   32'(busy),   32'd0);
    chk("rst.halted", 32'(halted), 32'd0);
    rst_n = 1'b1;

    // ADD: IDLE with start, then 7-cycle instruction.
    cyc(1, 1, 8'h03, 4'h0, 22'd0, 0, 0, 0, 0, "IDLE");
    fetch(8'h03);
    cyc(0, 1, 8'h03, 4'h0, c(3), 1, 0, 1, 0, "ADD.RD");
    cyc(0, 1, 8'h03, 4'h0, c(7), 0, 0, 1, 0, "ADD.BR");
    cyc(0, 1, 8'h03, 4'h0, c(9), 0, 0, 1, 0, "ADD.ALU");

    // STORE with three not-ready cycles in WR (9 cycles total).
    fetch(8'h01);
    cyc(0, 1, 8'h01, 4'h0, c(12),  0, 0, 1, 0, "ST");
    cyc(0, 0, 8'h01, 4'h0, 22'd0,  0, 1, 1, 0, "WR1");
    cyc(0, 0, 8'h01, 4'h0, 22'd0,  0, 1, 1, 0, "WR2");
    cyc(0, 0, 8'h01, 4'h0, 22'd0,  0, 1, 1, 0, "WR3");
    cyc(0, 1, 8'h01, 4'h0, c(11),  0, 1, 1, 0, "WR4");

    // LOAD clears ACC in BR and adds in ALU; DEC op changes afterwards are ignored.
    fetch(8'h02);
    cyc(0, 1, 8'h0E, 4'h0, c(3),        1, 0, 1, 0, "LD.RD");
    cyc(0, 1, 8'h0E, 4'h0, c(7) | c(8), 0, 0, 1, 0, "LD.BR");
    cyc(0, 1, 8'h0E, 4'h0, c(9),        0, 0, 1, 0, "LD.ALU");

    // JMPGEZ with N set: no jump.
    fetch(8'h05);
    cyc(0, 1, 8'h05, 4'b0100, 22'd0, 0, 0, 1, 0, "JGEZ.neg");
    // JMPGEZ with N clear: jump.
    fetch(8'h05);
    cyc(0, 1, 8'h05, 4'b0000, c(14), 0, 0, 1, 0, "JGEZ.pos");
    // Unconditional JMP ignores N.
    fetch(8'h06);
    cyc(0, 1, 8'h06, 4'b0100, c(14), 0, 0, 1, 0, "JMP");

    // SHL: ALU cycle asserts only C18.
    fetch(8'h0E);
    cyc(0, 1, 8'h0E, 4'h0, c(18), 0, 0, 1, 0, "SHL.ALU");

    // NOP: the following fetch's F0 lands right after DEC.
    fetch(8'hFF);
    fetch(8'h07);
    cyc(0, 1, 8'h07, 4'h0, 22'd0, 0, 0, 0, 1, "HALT");
    cyc(1, 1, 8'h00, 4'h0, 22'd0, 0, 0, 0, 1, "HALT.st1");
    cyc(1, 1, 8'h00, 4'h0, 22'd0, 0, 0, 0, 1, "HALT.st2");
    cyc(0, 1, 8'h00, 4'h0, 22'd0, 0, 0, 0, 1, "HALT.st0");
    #1 rst_n = 1'b0;
    #1;
    chk("hrst.halted", 32'(halted), 32'd0);
    chk("hrst.busy",   32'(busy),   32'd0);
    chk("hrst.ctrl",   32'(ctrl),   32'd0);
    rst_n = 1'b1;

    // Async reset while waiting in RD.
    cyc(1, 1, 8'h03, 4'h0, 22'd0, 0, 0, 0, 0, "IDLE2");
    fetch(8'h03);
    cyc(0, 0, 8'h03, 4'h0, 22'd0, 1, 0, 1, 0, "RDW");
    #1 rst_n = 1'b0;
    #1;
    chk("rdrst.rd",   32'(mem_rd), 32'd0);
    chk("rdrst.ctrl", 32'(ctrl),   32'd0);
    chk("rdrst.busy", 32'(busy),   32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(0, 1, 8'h00, 4'h0, 22'd0, 0, 0, 0, 0, "IDLE3");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
